// File: rtl/cal_satu_requant.sv
// Multi-lane requantiser: rounded arithmetic right shift, then saturation to OUT_W,
// two-stage valid/ready pipeline with per-lane saturation flags and a sticky event counter.
module cal_satu_requant #(
  parameter int IN_W    = 18,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   round_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       sat_flag,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   cnt_clr
);

  localparam int EXT_W = IN_W + 1;
  localparam int POP_W = $clog2(LANES + 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                         advance;
  logic                         s1_valid_q;
  logic signed [EXT_W-1:0]      s1_d [LANES];
  logic signed [EXT_W-1:0]      s1_q [LANES];
  logic                         out_valid_q;
  logic [LANES*OUT_W-1:0]       out_data_d;
  logic [LANES*OUT_W-1:0]       out_data_q;
  logic [LANES-1:0]             sat_flag_d;
  logic [LANES-1:0]             sat_flag_q;
  logic [CNT_W-1:0]             sat_cnt_d;
  logic [CNT_W-1:0]             sat_cnt_q;
  logic [POP_W-1:0]             pop;
  logic [CNT_W:0]               cnt_sum;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_flag_q;
  assign sat_cnt   = sat_cnt_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [EXT_W-1:0] ext_w;
      logic signed [EXT_W-1:0] rnd_w;
      logic                    sat_hi;
      logic                    sat_lo;

      // One spare bit so that rounding the most positive input cannot wrap.
      assign ext_w = $signed({in_data[gi*IN_W+IN_W-1], in_data[gi*IN_W +: IN_W]});
      assign rnd_w = (round_en && shift != '0)
                   ? $signed(EXT_W'(1) << (shift - SHIFT_W'(1))) : '0;
      assign s1_d[gi] = (ext_w + rnd_w) >>> shift;

      assign sat_hi = s1_q[gi] > SAT_MAX;
      assign sat_lo = s1_q[gi] < SAT_MIN;
      assign sat_flag_d[gi] = sat_hi || sat_lo;
      assign out_data_d[gi*OUT_W +: OUT_W] =
          sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
          sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                   s1_q[gi][OUT_W-1:0];
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + POP_W'(sat_flag_q[i]);
    end
    cnt_sum   = {1'b0, sat_cnt_q} + (CNT_W+1)'(pop);
    sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= '0;
      sat_cnt_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i] <= '0;
      end
    end else begin
      if (advance) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            s1_q[i] <= s1_d[i];
          end
        end
        if (s1_valid_q) begin
          out_data_q <= out_data_d;
          sat_flag_q <= sat_flag_d;
        end
      end
      // Clear takes priority and discards the count of a coincident transfer.
      if (cnt_clr) begin
        sat_cnt_q <= '0;
      end else if (out_valid_q && out_ready) begin
        sat_cnt_q <= sat_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_cal_satu_requant.sv
// Randomised and directed checks of cal_satu_requant against an integer-arithmetic model.
module tb_cal_satu_requant;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] in_data = '0;
  logic [3:0]  shift = '0;
  logic        round_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  sat_flag;
  logic [15:0] sat_cnt;
  logic        cnt_clr = 1'b0;
  logic        in_ready4;
  logic        out_valid4;
  logic [63:0] out_data4;
  logic [3:0]  sat_flag4;
  logic [3:0]  sat_cnt4;

  always #5 clk = ~clk;

  cal_satu_requant dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift(shift), .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  cal_satu_requant #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .shift(shift), .round_en(round_en),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .sat_flag(sat_flag4), .sat_cnt(sat_cnt4), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [63:0] d;
    logic [3:0]  f;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          cnt16_m = 0;
  int          cnt4_m = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] hold_data;
  logic [3:0]  hold_flag;
  bit          last_acc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Floor-divide by 2^sh after optional half-up bias, then clamp to int16.
  function automatic logic [16:0] ref_lane(input logic [17:0] x, input int sh, input bit rnd);
    longint v;
    longint d;
    longint q;
    v = longint'($signed(x));
    d = longint'(1) << sh;
    if (rnd && sh > 0) v = v + d / 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  function automatic beat_t ref_beat(input logic [71:0] din, input int sh, input bit rnd);
    beat_t       b;
    logic [16:0] r;
    b.d = '0;
    b.f = '0;
    b.cyc = 0;
    for (int i = 0; i < 4; i++) begin
      r = ref_lane(din[i*18 +: 18], sh, rnd);
      b.d[i*16 +: 16] = r[15:0];
      b.f[i] = r[16];
    end
    return b;
  endfunction

  function automatic logic [17:0] rand_lane();
    case ($urandom_range(0, 3))
      0: return 18'($urandom);
      1: return 18'h1FFFF - 18'($urandom_range(0, 40));
      2: return 18'h20000 + 18'($urandom_range(0, 40));
      default: return 18'($signed($urandom_range(0, 70000)) - 35000);
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, settle, then check and update the model.
  task automatic step(input bit vld, input logic [71:0] d, input int sh, input bit rnd,
                      input bit ordy, input bit clr);
    beat_t b;
    int    p;
    bit    xfer;
    @(negedge clk);
    in_valid = vld; in_data = d; shift = 4'(sh); round_en = rnd;
    out_ready = ordy; cnt_clr = clr;
    #1;
    check_val("sat_cnt", 64'(sat_cnt), 64'(cnt16_m));
    check_val("sat_cnt4", 64'(sat_cnt4), 64'(cnt4_m));
    if (prev_stall) begin
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_data", out_data, hold_data);
      check_val("hold_flag", 64'(sat_flag), 64'(hold_flag));
    end
    xfer = out_valid && out_ready;
    p = 0;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check_val("stale_beat", 64'd1, 64'd0);
      end else begin
        b = exp_q.pop_front();
        check_val("out_data", out_data, b.d);
        check_val("sat_flag", 64'(sat_flag), 64'(b.f));
        if (lat_chk) check_val("latency", 64'(cyc - b.cyc), 64'd2);
        p = $countones(b.f);
      end
    end
    if (clr) begin
      cnt16_m = 0;
      cnt4_m = 0;
    end else if (xfer) begin
      cnt16_m = (cnt16_m + p > 65535) ? 65535 : cnt16_m + p;
      cnt4_m  = (cnt4_m + p > 15) ? 15 : cnt4_m + p;
    end
    last_acc = vld && in_ready;
    if (last_acc) begin
      b = ref_beat(d, sh, rnd);
      b.cyc = cyc;
      exp_q.push_back(b);
    end
    prev_stall = out_valid && !out_ready;
    hold_data = out_data;
    hold_flag = sat_flag;
    $display("cyc %0d vld=%0b acc=%0b ordy=%0b out_valid=%0b out=%h flag=%b cnt=%0d",
             cyc, vld, last_acc, ordy, out_valid, out_data, sat_flag, sat_cnt);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [71:0] beats [4];
  logic [71:0] sat_beat;

  initial begin
    // Reset state
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_sat_flag", 64'(sat_flag), 64'd0);
    check_val("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed values with continuous out_ready: every beat has latency 2
    lat_chk = 1'b1;
    step(1'b1, {36'd0, 18'h06BC2, 18'h2EBC2}, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, {54'd0, 18'h2EBC2}, 2, 1'b1, 1'b1, 1'b0);
    step(1'b1, {54'd0, 18'h2EBC2}, 2, 1'b0, 1'b1, 1'b0);
    step(1'b1, {54'd0, 18'h1FFFF}, 1, 1'b1, 1'b1, 1'b0);
    step(1'b1, {54'd0, 18'h1FFFF}, 3, 1'b1, 1'b1, 1'b0);
    step(1'b1, {18'h20000, 18'h1FFFF, 18'h3FFFF, 18'h00001}, 15, 1'b1, 1'b1, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Stall: out_ready drops after two beats are accepted
    for (int i = 0; i < 4; i++)
      beats[i] = {rand_lane(), rand_lane(), 18'h1FFF0 + 18'(i), 18'($urandom)};
    step(1'b1, beats[0], 1, 1'b1, 1'b1, 1'b0);
    step(1'b1, beats[1], 2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, beats[2], 3, 1'b1, 1'b0, 1'b0);
    check_val("stall_in_ready", 64'(in_ready), 64'd0);
    check_val("stall_out_valid", 64'(out_valid), 64'd1);
    begin
      int idx = 2;
      for (int i = 0; i < 20 && idx < 4; i++) begin
        step(1'b1, beats[idx], idx + 1, idx[0], 1'b1, 1'b0);
        if (last_acc) idx++;
      end
      check_val("stall_all_sent", 64'(idx), 64'd4);
    end
    drain();

    // Random traffic with back-pressure and occasional clears
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0,
           {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    drain();

    // Counter saturation: 20 beats with exactly one saturating lane
    step(1'b0, '0, 0, 1'b0, 1'b1, 1'b1);
    sat_beat = {18'd5, 18'h3FFF0, 18'd100, 18'h1FFFF};
    for (int i = 0; i < 20; i++) step(1'b1, sat_beat, 0, 1'b0, 1'b1, 1'b0);
    check_val("cnt4_sticky", 64'(sat_cnt4), 64'd15);
    step(1'b1, sat_beat, 0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    check_val("clr_wins16", 64'(sat_cnt), 64'd0);
    check_val("clr_wins4", 64'(sat_cnt4), 64'd0);
    drain();

    // Asynchronous reset with two beats in flight
    for (int i = 0; i < 3; i++) step(1'b1, sat_beat, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_out_valid", 64'(out_valid), 64'd0);
    check_val("async_sat_cnt", 64'(sat_cnt), 64'd0);
    check_val("async_sat_cnt4", 64'(sat_cnt4), 64'd0);
    exp_q.delete();
    cnt16_m = 0;
    cnt4_m = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
      check_val("no_stale_valid", 64'(out_valid), 64'd0);
    end
    lat_chk = 1'b1;
    step(1'b1, {rand_lane(), rand_lane(), rand_lane(), rand_lane()}, 4, 1'b1, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cal_satu_requant.md
Name: cal_satu_requant

Overview:
Multi-lane, pipelined requantiser with a runtime shift. Each lane applies an arithmetic right shift with optional round-half-up, then saturates from IN_W-bit signed to OUT_W-bit signed. It sits between the INT18 MAC/accumulator outputs and the INT16 feature-map write path. It adds valid/ready flow control, per-lane saturation flags and a saturation event counter for layer-level overflow monitoring.

Parameters:
IN_W, 18, signed input width per lane
OUT_W, 16, signed output width per lane (OUT_W <= IN_W)
SHIFT_W, 4, width of runtime shift amount (shift range 0..2^SHIFT_W-1, must be < IN_W)
LANES, 4, number of parallel channels
CNT_W, 16, width of saturation event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], two's complement
shift  input  SHIFT_W  right-shift amount, sampled with the beat
round_en  input  1  1 = round-half-up before shift, sampled with the beat
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
sat_flag  output  LANES  per-lane saturation flag, aligned with out_data
sat_cnt  output  CNT_W  total saturated lanes since reset/clear, sticky at max
cnt_clr  input  1  synchronous clear of sat_cnt

Behaviour:
- Reset (rst_n=0, async): all pipeline valids=0; out_valid=0, out_data=0, sat_flag=0, sat_cnt=0. in_ready=1 once rst_n=1. Reset mid-stream drops in-flight beats; no partial output.
- Pipeline: 2 stages; latency is 2 cycles from accepted input (in_valid&&in_ready) to out_valid when out_ready stays high.
- Flow control: advance = !out_valid || out_ready; in_ready = advance (combinational). When advance=0 the whole pipeline freezes. out_data, sat_flag and out_valid stay stable while out_valid && !out_ready. Throughput is 1 beat/cycle with out_ready=1. A bubble (in_valid=0 on advance) propagates as valid=0.
- Stage 1 (per lane): sign-extend to IN_W+1 bits. If round_en && shift>0, add 2^(shift-1). Then arithmetic shift right by shift. shift=0 is a pass-through; round is ignored.
- Stage 2 (per lane): if value > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 and flag=1. If value < -2^(OUT_W-1), output -2^(OUT_W-1) and flag=1. Otherwise output low OUT_W bits and flag=0.
- The IN_W+1 intermediate guarantees rounding overflow (e.g. +max rounded up) saturates and never wraps.
- sat_cnt: on each output transfer (out_valid && out_ready), add popcount(sat_flag). The result is clamped at 2^CNT_W-1 and never wraps. Counting happens only on transfer, not while stalled.
- cnt_clr=1: sat_cnt <= 0 next edge. cnt_clr wins over a simultaneous increment, and that beat's count is discarded.
- shift/round_en travel with their beat. Changing them between beats affects only subsequent beats.

Test Plan:
- Lane0=18'h2EBC2 (-70718), lane1=18'h06BC2 (27586), shift=0, out_ready=1 -> 2 cycles later lane0=16'h8000 with flag=1, lane1=16'h6BC2 with flag=0, sat_cnt=1.
- Lane0=18'h2EBC2, shift=2: round_en=1 -> 16'hBAF1 (-17679); round_en=0 -> 16'hBAF0 (-17680); both flags 0.
- Lane0=18'h1FFFF (131071): shift=1, round_en=1 -> 16'h7FFF with flag=1 (rounding overflow, no wrap). shift=3, round_en=1 -> 16'h4000 (16384), flag=0.
- Stream 4 beats with out_ready held low after the first 2 accepted -> in_ready=0, out_data/out_valid frozen on beat 1. Release out_ready -> beats 1..4 emerge in order, none lost or duplicated, sat_cnt counts each once.
- CNT_W=4, 20 beats each with 1 saturated lane -> sat_cnt stops at 15. Then cnt_clr with a saturating beat transferring the same cycle -> sat_cnt=0.
- rst_n pulsed low asynchronously with 2 beats in flight -> out_valid=0 and sat_cnt=0 immediately. After release, no stale beat appears and the next beat has latency 2.
